// File: rtl/microtile_input_debounce.sv
// ----------------------------------------------------------------------------
// microtile_input_debounce
//
// Input-conditioning stage in front of a microtile's ui_in bus. Each of the
// eight raw lines is synchronized through its own flop chain and then
// debounced independently: a new level is accepted only after the
// synchronized value has disagreed with the current output for
// DEBOUNCE_CYCLES consecutive enabled clock edges. Any agreement in between
// clears the qualification count (no partial credit).
//
// Parameters:
//   SYNC_STAGES     synchronizer flops per bit (>= 2)
//   DEBOUNCE_CYCLES consecutive enabled edges a new level must persist (>= 1)
//   RESET_VALUE     value of ui_in and of every synchronizer flop in reset
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous active-low reset
//   ena     in   1  debounce enable; low freezes counters and ui_in
//   raw_in  in   8  unsynchronized input lines
//   ui_in   out  8  debounced, registered bus
//   rise    out  8  one-cycle pulse per bit on a 0->1 change of ui_in
//   fall    out  8  one-cycle pulse per bit on a 1->0 change of ui_in
//   busy    out  1  registered OR of (counter != 0) over all bits
//
// Output timing contract: there is no handshake. ui_in, rise, fall and busy
// are all registered and change together on the same edge; a rise/fall pulse
// is high in exactly the cycle where ui_in first shows the new level, and
// busy reflects the counter values held in that same cycle.
// ----------------------------------------------------------------------------
module microtile_input_debounce #(
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [7:0] RESET_VALUE     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] raw_in,
    output logic [7:0] ui_in,
    output logic [7:0] rise,
    output logic [7:0] fall,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the next mismatching edge completes qualification.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer: shifts every edge regardless of ena. Preloading with
    // RESET_VALUE means a raw bus already at RESET_VALUE produces no
    // candidate change once reset is released.
    // ------------------------------------------------------------------
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-bit qualification counters (the only per-bit state: 0 = idle,
    // 1..DEBOUNCE_CYCLES-1 = qualifying a candidate level).
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_d [8];
    logic [7:0]    ui_d;
    logic [7:0]    rise_d;
    logic [7:0]    fall_d;
    logic          busy_d;

    always_comb begin
        ui_d   = ui_in;
        busy_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (ena) begin
            for (int i = 0; i < 8; i++) begin
                if (s[i] == ui_in[i]) begin
                    // Glitch rejection: any agreement discards progress.
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    ui_d[i]  = s[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        // busy is registered alongside the counters, so it tracks the
        // counter registers with zero cycles of lag.
        for (int i = 0; i < 8; i++) begin
            busy_d = busy_d | (cnt_d[i] != '0);
        end

        // With ena low ui_d equals ui_in, so both pulse vectors are zero.
        rise_d = ui_d & ~ui_in;
        fall_d = ~ui_d & ui_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
            ui_in <= RESET_VALUE;
            rise  <= '0;
            fall  <= '0;
            busy  <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ui_in <= ui_d;
            rise  <= rise_d;
            fall  <= fall_d;
            busy  <= busy_d;
        end
    end

endmodule

// File: doc/microtile_input_debounce.md
# microtile_input_debounce

Input-conditioning stage that sits directly upstream of a microtile's `ui_in` bus. It takes eight raw, asynchronous lines from pads, switches or a bench, synchronizes and debounces each bit independently, and drives a clean `ui_in` bus. It also provides per-bit one-cycle edge pulses and a busy flag, so sequential tiles and test logic can consume clean events.

## Interface
Parameters:
- `SYNC_STAGES`, default 2, synchronizer flops per bit; legal range is 2 or more.
- `DEBOUNCE_CYCLES`, default 4, consecutive clock edges a new level must persist before it is accepted; legal range is 1 or more.
- `RESET_VALUE`, default 8'h00, value of `ui_in` during and after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  debounce enable; when low, the debounced state is frozen.
- `raw_in`  in  8  unsynchronized input lines.
- `ui_in`  out  8  debounced bus, registered, feeding the microtile.
- `rise`  out  8  one-cycle pulse per bit when `ui_in[i]` goes 0 to 1.
- `fall`  out  8  one-cycle pulse per bit when `ui_in[i]` goes 1 to 0.
- `busy`  out  1  high while any bit's counter is nonzero, meaning a candidate change is pending.

## Operation
- **Reset.** While `rst_n` is low, these values hold asynchronously:
  - all synchronizer flops = `RESET_VALUE`;
  - `ui_in` = `RESET_VALUE`;
  - all counters = 0;
  - `rise`, `fall` = 0;
  - `busy` = 0.
- **Synchronizer.** Each bit has a chain of `SYNC_STAGES` flops.
  - The chain shifts every edge, regardless of `ena`.
  - `s[i]` is the last stage of the chain.
- **Per-bit counter.** Width is clog2(`DEBOUNCE_CYCLES`+1). On each edge with `ena`=1:
  - If `s[i]` == `ui_in[i]`: counter clears to 0. This is glitch rejection; there is no partial credit.
  - If `s[i]` != `ui_in[i]` and counter == `DEBOUNCE_CYCLES`-1: `ui_in[i]` takes `s[i]`, and the counter clears to 0.
  - Otherwise the counter increments.
- **ena low.**
  - Counters hold their values.
  - `ui_in` holds.
  - `rise`/`fall` are 0.
  - When `ena` returns high, counting resumes from the held counter value.
- **Edge pulses.**
  - `rise[i]` and `fall[i]` are registered and asserted in the same cycle that `ui_in[i]` shows its new value.
  - Each pulse lasts exactly one cycle.
  - `rise[i]` and `fall[i]` are never both high.
- **Bit independence.** Bits are fully independent; any number of bits may update on the same edge.
- **busy.** `busy` is the registered OR of (counter != 0) across all bits, and follows the counters by zero cycles.
- **No state machine beyond the per-bit counter.** Each bit is either idle (counter = 0) or qualifying (counter from 1 to `DEBOUNCE_CYCLES`-1).

## Timing
- **Step latency.** `raw_in[i]` changes between edges and then stays stable; call the next rising edge edge 1.
  - `s[i]` shows the new value after edge `SYNC_STAGES`.
  - `ui_in[i]` changes at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - With the defaults this is edge 6.
- **Pulse acceptance.**
  - A raw pulse seen by `s[i]` for fewer than `DEBOUNCE_CYCLES` edges is rejected: `ui_in` is unchanged and the counter returns to 0.
  - A pulse seen for exactly `DEBOUNCE_CYCLES` edges is accepted.
- **Sustained bouncing.** A raw line that toggles faster than every `DEBOUNCE_CYCLES` cycles never changes `ui_in`.
- **DEBOUNCE_CYCLES = 1.** `ui_in` follows `s` with one edge of delay, and `busy` stays 0.
- **Reset mid-count.** Asserting `rst_n` low mid-count aborts all pending changes immediately. After release, the first change is timed from scratch per the step-latency rule.
- **Reset release.**
  - `rst_n` release is synchronous to `clk` in the system.
  - The synchronizer preloaded with `RESET_VALUE` guarantees no spurious pulse after release when `raw_in` == `RESET_VALUE`.

## Test plan
- **Reset:** `RESET_VALUE`=8'hA5 with `raw_in`=8'hA5, pulse `rst_n` low for 3 cycles -> `ui_in`=8'hA5 at once; `rise`=`fall`=0 and `busy`=0 both during reset and for 20 cycles after.
- **Clean step:** defaults (`SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4), `raw_in` 8'h00 to 8'h01 -> `ui_in` becomes 8'h01 at edge 6, `rise`=8'h01 for exactly one cycle, `busy` high at edges 3–5 and low from edge 6.
- **Glitch threshold:** 3-cycle high pulse on `raw_in[3]` -> no change on `ui_in` and no pulse. 4-cycle pulse -> `ui_in[3]` high for exactly 4 cycles, one `rise[3]` pulse, one `fall[3]` pulse.
- **Bounce then settle:** on `raw_in[7]`, 10 toggles at a 2-cycle period, then stable high -> single `rise[7]`, occurring 6 edges after the final raw transition.
- **ena hold:** `ena` dropped after 2 mismatch edges, held low 10 cycles, then raised -> counter holds at 2, `ui_in` updates 2 edges after `ena` returns high, and no pulses while `ena` is low.
- **Simultaneous bits and reset mid-count:** `raw_in` 8'h00 to 8'hFF -> all bits update together with `rise`=8'hFF. In a second run, `rst_n` is asserted at edge 4 of a pending change -> counters = 0, `busy`=0, `ui_in`=`RESET_VALUE`, and no pulse after release.
